// File: rtl/memory_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | memory_arbiter: round-robin fetch/data arbiter onto one memory port.      |
// | Optional: ARB_TIMEOUT_EN (abort after TIMEOUT mem_ready-low cycles). r1.0 |
// +--------------------------------------------------------------------------+
module memory_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state;
  logic   last_data;
  logic   if_elig;
  logic   d_elig;
  logic   pick_d;
  logic   expire;

  // A requester whose ack is showing is still holding req for one more cycle.
  assign if_elig = if_req & ~if_ack;
  assign d_elig  = d_req & ~d_ack;
  assign pick_d  = d_elig & (~if_elig | ~last_data);
  assign stall   = (if_req & ~if_ack) | (d_req & ~d_ack);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tcnt;

  assign expire = (tcnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == IDLE) begin
        tcnt <= '0;
      end else if (!mem_ready) begin
        tcnt <= tcnt + CNT_W'(1);
        if (expire) err <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire         = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_data <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_elig | d_elig) begin
            mem_valid <= 1'b1;
            if (pick_d) begin
              state     <= BUSY_D;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              state     <= BUSY_I;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // An aborted access (expire without mem_ready) returns zero data.
          if (mem_ready | expire) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            last_data <= (state == BUSY_D);
            if (state == BUSY_I) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata[31:0] : 32'd0;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= mem_ready ? mem_rdata : '0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// tb_memory_arbiter: randomized scoreboard bench for memory_arbiter with a
// transaction-level reference model and a behavioural memory responder.
module tb_memory_arbiter;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int TIMEOUT = 16;
  localparam int NONE = 0;
  localparam int FI   = 1;
  localparam int DA   = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic              stall;
  logic              err;

  memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } op_t;

  int  checks = 0;
  int  errors = 0;
  op_t fq[$];
  op_t dq[$];
  int  grant_log[$];
  bit  if_pend = 1'b0;
  bit  d_pend = 1'b0;
  int  fixed_wait = 0;
  bit  hold_forever = 1'b0;

  function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    if (a == 64'h40) return 64'h0000_0000_0050_0093;
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue_fetch(input logic [ADDR_W-1:0] a);
    op_t o;
    o.we = 1'b0; o.addr = a; o.wdata = '0;
    fq.push_back(o);
    if_addr = a; if_req = 1'b1; if_pend = 1'b1;
  endtask

  task automatic issue_data(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    op_t o;
    o.we = we; o.addr = a; o.wdata = wd;
    dq.push_back(o);
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1; d_pend = 1'b1;
  endtask

  task automatic wait_fetch(output int lat);
    bit got = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1; lat++;
      if (if_ack) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL fetch_ack_timeout: no if_ack after %0d cycles, required one", lat);
      if_pend = 1'b0; fq.delete();
    end
    @(posedge clock); #1;
    if_req = 1'b0; if_addr = {$urandom, $urandom};
  endtask

  task automatic wait_data(output int lat);
    bit got = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1; lat++;
      if (d_ack) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL data_ack_timeout: no d_ack after %0d cycles, required one", lat);
      d_pend = 1'b0; dq.delete();
    end
    @(posedge clock); #1;
    d_req = 1'b0; d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
  endtask

  task automatic fetch_stream(input int n);
    int lat;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(1, 3)) @(posedge clock);
      #1;
      issue_fetch({$urandom, $urandom} & ~64'h3);
      wait_fetch(lat);
    end
  endtask

  task automatic data_stream(input int n);
    int lat;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(1, 3)) @(posedge clock);
      #1;
      issue_data(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
      wait_data(lat);
    end
  endtask

  // Memory: each access sees a chosen number of not-ready cycles, then its data.
  initial begin : responder
    int wcnt;
    bit prev;
    wcnt = 0; prev = 1'b0;
    forever begin
      @(posedge clock); #2;
      if (mem_valid && reset) begin
        if (!prev)
          wcnt = hold_forever ? 1000000 : (fixed_wait >= 0 ? fixed_wait : int'($urandom_range(0, 3)));
        if (wcnt == 0) begin
          mem_ready = 1'b1; mem_rdata = mem_fn(mem_addr);
        end else begin
          mem_ready = 1'b0; wcnt--; mem_rdata = {$urandom, $urandom};
        end
      end else begin
        mem_ready = 1'b0; mem_rdata = {$urandom, $urandom};
      end
      prev = mem_valid && reset;
    end
  end

  // Reference model: one transaction per grant, round-robin on ties, ack one
  // cycle after the memory accepts; responses come from the issue queues.
  initial begin : monitor
    int exp_ack, cur, winner, wcnt;
    bit exp_err, busy, grant_exp, last_d, exp_stall;
    op_t o;
    logic [DATA_W-1:0] er;
    exp_ack = NONE; cur = NONE; winner = NONE; wcnt = 0;
    exp_err = 1'b0; busy = 1'b0; grant_exp = 1'b0; last_d = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_ack = NONE; exp_err = 1'b0; busy = 1'b0; grant_exp = 1'b0;
        last_d = 1'b0; wcnt = 0;
        continue;
      end
      chk("if_ack", if_ack, exp_ack == FI);
      chk("d_ack", d_ack, exp_ack == DA);
      chk("err", err, exp_err);
      if (exp_ack == FI) begin
        if (fq.size() > 0) begin
          o = fq.pop_front();
          er = exp_err ? '0 : mem_fn(o.addr);
          chk("if_rdata", if_rdata, er[31:0]);
        end
        if_pend = 1'b0; last_d = 1'b0;
      end else if (exp_ack == DA) begin
        if (dq.size() > 0) begin
          o = dq.pop_front();
          er = exp_err ? '0 : mem_fn(o.addr);
          if (!o.we || exp_err) chk("d_rdata", d_rdata, er);
        end
        d_pend = 1'b0; last_d = 1'b1;
      end
      exp_stall = (if_req && exp_ack != FI) || (d_req && exp_ack != DA);
      chk("stall", stall, exp_stall);

      if (!busy) begin
        chk("grant", mem_valid, grant_exp);
        if (mem_valid) begin
          busy = 1'b1; cur = winner; wcnt = 0; grant_log.push_back(winner);
        end
      end
      exp_ack = NONE; exp_err = 1'b0;
      if (busy) begin
        chk("mem_valid_busy", mem_valid, 1'b1);
        if ((cur == FI && fq.size() == 0) || (cur == DA && dq.size() == 0)) begin
          checks++; errors++;
          $display("FAIL grant_owner: granted requester %0d has no outstanding request", cur);
        end else begin
          o = (cur == FI) ? fq[0] : dq[0];
          chk("mem_addr", mem_addr, o.addr);
          chk("mem_we", mem_we, o.we);
          chk("mem_wdata", mem_wdata, o.wdata);
        end
        if (!mem_valid) begin
          busy = 1'b0;
        end else if (mem_ready) begin
          exp_ack = cur; busy = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          wcnt++;
          if (wcnt == TIMEOUT) begin exp_ack = cur; exp_err = 1'b1; busy = 1'b0; end
        end
`endif
      end
      grant_exp = 1'b0;
      if (!mem_valid) begin
        grant_exp = if_pend || d_pend;
        winner = (d_pend && (!if_pend || !last_d)) ? DA : FI;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int l1, l2;
    repeat (3) @(posedge clock);
    #1;
    chk("rst mem_valid", mem_valid, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst mem_addr", mem_addr, '0);
    chk("rst mem_wdata", mem_wdata, '0);
    chk("rst if_ack", if_ack, 1'b0);
    chk("rst d_ack", d_ack, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst if_rdata", if_rdata, '0);
    chk("rst d_rdata", d_rdata, '0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Simultaneous requests after reset: data wins the first tie.
    fixed_wait = 0;
    grant_log.delete();
    issue_data(1'b1, 64'h100, 64'hDEAD);
    issue_fetch(64'h80);
    fork
      wait_data(l1);
      wait_fetch(l2);
    join
    chk("tie grant count", grant_log.size(), 2);
    chk("tie first grant", grant_log[0], DA);
    chk("tie second grant", grant_log[1], FI);
    chk("tie data latency", l1, 2);
    chk("tie fetch latency", l2, 4);

    @(posedge clock); #1;
    issue_fetch(64'h40);
    wait_fetch(l1);
    chk("single fetch latency", l1, 2);
    chk("single fetch if_rdata", if_rdata, 32'h0050_0093);

    fixed_wait = 3;
    @(posedge clock); #1;
    issue_fetch(64'h40);
    wait_fetch(l1);
    chk("wait-state latency", l1, 5);

    fixed_wait = 0;
    grant_log.delete();
    for (int r = 0; r < 2; r++) begin
      @(posedge clock); #1;
      issue_data(1'b0, {$urandom, $urandom}, {$urandom, $urandom});
      issue_fetch({$urandom, $urandom});
      fork
        wait_data(l1);
        wait_fetch(l2);
      join
    end
    chk("rr grant count", grant_log.size(), 4);
    chk("rr grant 0", grant_log[0], DA);
    chk("rr grant 1", grant_log[1], FI);
    chk("rr grant 2", grant_log[2], DA);
    chk("rr grant 3", grant_log[3], FI);

    fixed_wait = -1;
    fork
      fetch_stream(60);
      data_stream(60);
    join

    // Reset in the middle of a data access.
    hold_forever = 1'b1;
    @(posedge clock); #1;
    issue_data(1'b0, 64'h2000, '0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (mem_valid) break;
    end
    chk("mid-reset access started", mem_valid, 1'b1);
    @(negedge clock); #1;
    reset = 1'b0;
    #1;
    chk("mid-reset mem_valid", mem_valid, 1'b0);
    d_req = 1'b0; d_pend = 1'b0; dq.delete(); hold_forever = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("mid-reset no d_ack", d_ack, 1'b0);
    end
    reset = 1'b1;
    fixed_wait = 0;
    grant_log.delete();
    @(posedge clock); #1;
    issue_fetch(64'h40);
    issue_data(1'b0, 64'h2000, '0);
    fork
      wait_data(l1);
      wait_fetch(l2);
    join
    chk("post-reset first grant", grant_log[0], DA);
    chk("post-reset data latency", l1, 2);

`ifdef ARB_TIMEOUT_EN
    hold_forever = 1'b1;
    @(posedge clock); #1;
    issue_data(1'b0, 64'h3000, '0);
    wait_data(l1);
    chk("timeout latency", l1, TIMEOUT + 1);
    chk("timeout d_rdata", d_rdata, '0);
    hold_forever = 1'b0;
`endif

    repeat (5) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, meaning the address width for all ports.
REQ-002 The block SHALL have parameter DATA_W, default 64, meaning the data bus width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning the number of mem_ready-low cycles before abort.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-006 The block SHALL have ports if_req (in, 1), if_addr (in, ADDR_W), if_ack (out, 1) and if_rdata (out, 32), forming the instruction-fetch requester.
REQ-007 The block SHALL have ports d_req (in, 1), d_we (in, 1), d_addr (in, ADDR_W), d_wdata (in, DATA_W), d_ack (out, 1) and d_rdata (out, DATA_W), forming the data load/store requester.
REQ-008 The block SHALL have ports mem_valid (out, 1), mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, DATA_W), mem_rdata (in, DATA_W) and mem_ready (in, 1), forming the shared single-port memory.
REQ-009 The block SHALL have port stall, output, 1 bit: processor hold request.
REQ-010 The block SHALL have port err, output, 1 bit: pulse alongside an ack for an aborted access.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY_I and BUSY_D.
REQ-012 IDLE SHALL move to BUSY_I or BUSY_D on the edge where at least one eligible request is sampled, and SHALL otherwise stay in IDLE.
REQ-013 A requester SHALL be ineligible in any cycle in which its own ack is high.
REQ-014 With exactly one eligible request, that requester SHALL be granted.
REQ-015 With both requests eligible, the requester not granted last SHALL be granted (round-robin); the last-grant flag SHALL reset to "fetch", so data wins the first tie.
REQ-016 On the grant edge, mem_addr, mem_we and mem_wdata SHALL be registered from the winner; fetch SHALL set mem_we=0 and mem_wdata=0.
REQ-017 mem_valid SHALL be 1 exactly while in a BUSY state, with mem_addr, mem_we and mem_wdata held constant.
REQ-018 In BUSY_x with mem_ready=1: on that edge, register the ack for x and the rdata for x from mem_rdata (if_rdata takes mem_rdata[31:0]; d_rdata on writes is don't-care), then return to IDLE.
REQ-019 if_ack and d_ack SHALL be one-cycle pulses; if_rdata and d_rdata SHALL hold their value until the next ack to the same requester.
REQ-020 Minimum latency: req sampled at edge 0, mem_valid in cycle 1, mem_ready in cycle 1, ack in cycle 2; each extra mem_ready-low cycle adds one cycle.
REQ-021 Requesters SHALL hold req and operands stable until ack and drop req the cycle after ack; the block SHALL NOT tolerate a mid-request operand change.
REQ-022 stall SHALL be combinational: (if_req & ~if_ack) | (d_req & ~d_ack).
REQ-023 A request arriving while the other requester is BUSY SHALL wait, with no loss, and be granted from the following IDLE.
REQ-024 Both acks SHALL never be high in the same cycle.

Reset
REQ-025 reset low SHALL immediately force: state IDLE; last-grant = fetch; mem_valid, mem_we, if_ack, d_ack and err = 0; mem_addr, mem_wdata, if_rdata and d_rdata = 0; timeout counter = 0.
REQ-026 Reset asserted mid-access SHALL abandon the access without an ack; the first grant after release SHALL follow REQ-012.

Configuration
REQ-027 With macro ARB_TIMEOUT_EN defined, a counter SHALL clear on grant and increment on each BUSY cycle with mem_ready=0.
REQ-028 With ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT the block SHALL: return to IDLE, pulse the current requester's ack with err=1 and rdata=0, and update last-grant as for a normal completion.
REQ-029 With ARB_TIMEOUT_EN undefined, there SHALL be no counter, err SHALL be tied 0 and BUSY SHALL wait indefinitely for mem_ready.

Verification
REQ-030 Single fetch: if_req=1, if_addr=0x40, mem_ready=1 in the first mem_valid cycle, mem_rdata=0x00500093 -> if_ack at cycle 2, if_rdata=0x00500093, mem_we=0 throughout.
REQ-031 Simultaneous after reset: if_req=d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD -> data granted first (mem_we=1, mem_addr=0x100); fetch granted on the following IDLE; acks never overlap.
REQ-032 Back-to-back ties: both requests reissued each time for 4 transactions -> grants alternate D,I,D,I.
REQ-033 Wait states: mem_ready held low 3 cycles -> mem_addr stable, stall=1 throughout, ack 3 cycles later than in REQ-030.
REQ-034 Mid-access reset: reset pulled low during BUSY_D -> mem_valid=0 the same cycle, no d_ack, and a clean grant after release.
REQ-035 With ARB_TIMEOUT_EN defined and TIMEOUT=16: mem_ready never asserted -> d_ack and err pulse 16 cycles after grant, d_rdata=0, state IDLE.
